mem_stage: RTL and testbench

//   MEM pipeline stage: consumes EX/MEM latch outputs, resolves the branch, accesses

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_stage_data_mem.sv | 25 ++
 rtl/mem_stage.sv | 71 +++++++
 tb/tb_mem_stage.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths and the MEM/WB latch record for the MEM stage.
package mem_stage_pkg;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int PC_W = 7;
  localparam int STAT_W = 16;
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic [DATA_W-1:0] alu_result;
    logic [REG_ADDR_W-1:0] dst;
  } mem_wb_t;
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + 1'b1 : v;
  endfunction
endpackage

// File: rtl/mem_stage_data_mem.sv
// data_mem: word-addressed data memory, synchronous write, read-first registered read.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;
  always_comb rdata_d = rst ? '0 : re ? mem[addr] : rdata_q;
  // Contents survive reset; only the store is suppressed.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[addr] <= wdata;
  end
  always_ff @(posedge clk) rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage (branch resolve, data memory, MEM/WB latch).
// Optional MEM_STATS_EN adds saturating load/store counters.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_to_reg,
  input  logic                  reg_write,
  input  logic                  branch,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic [PC_W-1:0]       pc_branch,
  input  logic                  zero,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     data2,
  input  logic [REG_ADDR_W-1:0] dst,
  input  logic                  flush,
  output logic                  pc_src,
  output logic [PC_W-1:0]       pc_target,
  output logic                  wb_mem_to_reg,
  output logic                  wb_reg_write,
  output logic [DATA_W-1:0]     wb_read_data,
  output logic [DATA_W-1:0]     wb_alu_result,
  output logic [REG_ADDR_W-1:0] wb_dst
`ifdef MEM_STATS_EN
  ,
  output logic [STAT_W-1:0]     load_count,
  output logic [STAT_W-1:0]     store_count
`endif
);
  mem_wb_t wb_d, wb_q;
  logic [ADDR_W-1:0] word_addr;
  logic unused_addr_bits;
  assign pc_src = branch & zero;
  assign pc_target = pc_branch;
  // Byte offset and bits above the memory range are dropped, so addresses wrap.
  assign word_addr = alu_result[ADDR_W+1:2];
  assign unused_addr_bits = ^{alu_result[DATA_W-1:ADDR_W+2], alu_result[1:0]};
  data_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_data_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_write & ~flush),
    .re    (mem_read),
    .addr  (word_addr),
    .wdata (data2),
    .rdata (wb_read_data)
  );
  always_comb wb_d = rst ? '0 : mem_wb_t'{mem_to_reg: mem_to_reg & ~flush, reg_write: reg_write & ~flush, alu_result: alu_result, dst: dst};
  always_ff @(posedge clk) wb_q <= wb_d;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_alu_result = wb_q.alu_result;
  assign wb_dst = wb_q.dst;
`ifdef MEM_STATS_EN
  logic [STAT_W-1:0] load_count_d, load_count_q, store_count_d, store_count_q;
  always_comb begin
    load_count_d = rst ? '0 : sat_inc(load_count_q, mem_read & ~flush);
    store_count_d = rst ? '0 : sat_inc(store_count_q, mem_write & ~flush);
  end
  always_ff @(posedge clk) begin
    load_count_q <= load_count_d;
    store_count_q <= store_count_d;
  end
  assign load_count = load_count_q;
  assign store_count = store_count_q;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
  logic clk = 0, rst = 1;
  logic mem_to_reg = 0, reg_write = 0, branch = 0, mem_write = 0, mem_read = 0, zero = 0, flush = 0;
  logic [6:0] pc_branch = 0;
  logic [31:0] alu_result = 0, data2 = 0;
  logic [4:0] dst = 0;
  logic pc_src, wb_mem_to_reg, wb_reg_write;
  logic [6:0] pc_target;
  logic [31:0] wb_read_data, wb_alu_result;
  logic [4:0] wb_dst;
  int n_chk = 0, n_pass = 0;
`ifdef MEM_STATS_EN
  logic [15:0] load_count, store_count;
`endif
  always #5 clk = ~clk;
  mem_stage dut (
    .clk(clk), .rst(rst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch(branch),
    .mem_write(mem_write), .mem_read(mem_read), .pc_branch(pc_branch), .zero(zero),
    .alu_result(alu_result), .data2(data2), .dst(dst), .flush(flush), .pc_src(pc_src),
    .pc_target(pc_target), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .wb_dst(wb_dst)
`ifdef MEM_STATS_EN
    , .load_count(load_count), .store_count(store_count)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    mem_write = wr; mem_read = rd; alu_result = a; data2 = d;
    step();
  endtask
  task automatic chk_wb_zero(input string tag);
    chk({tag, "_m2r"}, {31'b0, wb_mem_to_reg}, 0);
    chk({tag, "_rw"}, {31'b0, wb_reg_write}, 0);
    chk({tag, "_rd"}, wb_read_data, 0);
    chk({tag, "_alu"}, wb_alu_result, 0);
    chk({tag, "_dst"}, {27'b0, wb_dst}, 0);
  endtask
  initial begin
    rst = 1; mem_write = 1; alu_result = 32'h40; data2 = 32'hFFFF_FFFF; reg_write = 1; mem_to_reg = 1; dst = 5'd7;
    step();
    chk_wb_zero("reset");
    rst = 0; reg_write = 0; mem_to_reg = 0; dst = 0;
    op(1, 0, 32'd8, 32'hDEADBEEF);
    chk("store_alu", wb_alu_result, 32'd8);
    mem_to_reg = 1; reg_write = 1; dst = 5'd3;
    op(0, 1, 32'd8, 0);
    chk("load8", wb_read_data, 32'hDEADBEEF);
    chk("load_rw", {31'b0, wb_reg_write}, 1);
    chk("load_m2r", {31'b0, wb_mem_to_reg}, 1);
    chk("load_dst", {27'b0, wb_dst}, 3);
    branch = 1; zero = 1; pc_branch = 7'h2A; #1;
    chk("br_taken", {31'b0, pc_src}, 1);
    chk("br_target", {25'b0, pc_target}, 32'h2A);
    zero = 0; #1;
    chk("br_nz", {31'b0, pc_src}, 0);
    branch = 0; zero = 1; #1;
    chk("br_nobr", {31'b0, pc_src}, 0);
    zero = 0; mem_to_reg = 0; reg_write = 0; dst = 0;
    op(0, 0, 32'd100, 0);
    chk("hold_rd", wb_read_data, 32'hDEADBEEF);
    op(1, 0, 32'd4, 32'd1);
    op(1, 1, 32'd4, 32'd2);
    chk("rdfirst_old", wb_read_data, 32'd1);
    op(0, 1, 32'd4, 0);
    chk("rdfirst_new", wb_read_data, 32'd2);
    op(1, 0, 32'd524, 32'h55);
    op(0, 1, 32'd12, 0);
    chk("wrap12", wb_read_data, 32'h55);
    op(0, 1, 32'd13, 0);
    chk("wrap13", wb_read_data, 32'h55);
    op(0, 1, 32'd8, 0);
    chk("wrap_intact8", wb_read_data, 32'hDEADBEEF);
    op(1, 0, 32'd20, 32'h11);
    reg_write = 1; mem_to_reg = 1; flush = 1;
    op(1, 0, 32'd20, 32'h77);
    chk("flush_rw", {31'b0, wb_reg_write}, 0);
    chk("flush_m2r", {31'b0, wb_mem_to_reg}, 0);
    flush = 0; reg_write = 0; mem_to_reg = 0;
    op(0, 1, 32'd20, 0);
    chk("flush_nostore", wb_read_data, 32'h11);
    rst = 1; reg_write = 1; mem_to_reg = 1; dst = 5'd9;
    op(1, 0, 32'd8, 32'hBAD);
    chk_wb_zero("rst_mid");
    rst = 0;
    op(0, 1, 32'd8, 0);
    chk("rst_mem_kept", wb_read_data, 32'hDEADBEEF);
    chk("post_rst_dst", {27'b0, wb_dst}, 9);
    chk("post_rst_rw", {31'b0, wb_reg_write}, 1);
    chk("post_rst_alu", wb_alu_result, 32'd8);
`ifdef MEM_STATS_EN
    reg_write = 0; mem_to_reg = 0; dst = 0;
    rst = 1; op(0, 0, 0, 0); rst = 0;
    chk("cnt_rst_ld", {16'b0, load_count}, 0);
    chk("cnt_rst_st", {16'b0, store_count}, 0);
    op(0, 1, 32'd0, 0);
    op(1, 0, 32'd40, 32'h1);
    op(0, 1, 32'd4, 0);
    flush = 1; op(1, 0, 32'd44, 32'h2); flush = 0;
    op(1, 0, 32'd48, 32'h3);
    op(0, 1, 32'd8, 0);
    op(0, 0, 0, 0);
    chk("cnt_ld3", {16'b0, load_count}, 3);
    chk("cnt_st2", {16'b0, store_count}, 2);
    mem_read = 1;
    repeat (65540) @(posedge clk);
    #1;
    mem_read = 0;
    chk("cnt_sat", {16'b0, load_count}, 32'hFFFF);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
